pnm_cmd_sequencer: RTL

Command queue and sequencer in front of the PNM controller. Buffers scheduler commands (opcode plus start/end/result addresses) in a FIFO and validates each one. It issues one command at a time to the PNM controller as a single-cycle start strobe. It then tracks the command through PIM-ready gating and completion, and reports per-command done or error status back to the scheduler.

---
 rtl/pnm_pkg.sv | 25 ++
 rtl/pnm_cmd_sequencer_if.sv | 24 ++
 rtl/pnm_cmd_fifo.sv | 53 +++++
 rtl/pnm_cmd_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pnm_pkg.sv
// Shared constants, FSM state type and opcode check for the PNM command sequencer.
package pnm_pkg;

    localparam logic [5:0] RELU     = 6'b010111;
    localparam logic [5:0] MAX_POOL = 6'b110011;
    localparam logic [5:0] MOVE     = 6'b110111;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT_EN,
        S_RUN
    } seq_state_e;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == RELU) || (op == MAX_POOL) || (op == MOVE);
    endfunction

endpackage

// File: rtl/pnm_cmd_sequencer_if.sv
// Scheduler-side command channel: request fields in, per-command status out.
interface pnm_cmd_sequencer_if #(parameter int Address_Size = 16);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [5:0]              cmd_op;
    logic [Address_Size-1:0] cmd_start_addr;
    logic [Address_Size-1:0] cmd_end_addr;
    logic [Address_Size-1:0] cmd_result_addr;
    logic                    cmd_done;
    logic                    cmd_error;
    logic [1:0]              err_code;

    modport master (
        output cmd_valid, cmd_op, cmd_start_addr, cmd_end_addr, cmd_result_addr,
        input  cmd_ready, cmd_done, cmd_error, err_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_start_addr, cmd_end_addr, cmd_result_addr,
        output cmd_ready, cmd_done, cmd_error, err_code
    );

endinterface

// File: rtl/pnm_cmd_fifo.sv
// Synchronous show-ahead FIFO; push while full and pop while empty are ignored.
module pnm_cmd_fifo #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pnm_cmd_sequencer.sv
// Queues scheduler commands, validates them and issues one at a time to the PNM controller.
// Optional watchdog on WAIT_EN/RUN is compiled in with PNM_SEQ_WATCHDOG_EN.
module pnm_cmd_sequencer
    import pnm_pkg::*;
#(
    parameter int Address_Size   = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    pnm_cmd_sequencer_if.slave            cmd,
    output logic [5:0]                    ctl_command,
    output logic [Address_Size-1:0]       ctl_start_addr,
    output logic [Address_Size-1:0]       ctl_end_addr,
    output logic [Address_Size-1:0]       ctl_result_addr,
    output logic                          ctl_data_write,
    input  logic                          ctl_en,
    input  logic                          ctl_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int W = 6 + 3 * Address_Size;

    seq_state_e              state, next;
    logic [W-1:0]            head;
    logic                    full, empty, pop;
    logic [5:0]              op_q;
    logic [Address_Size-1:0] start_q, end_q, res_q;
    logic                    err_set, done_set, wd_expired;
    logic [1:0]              err_val;

    pnm_cmd_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd.cmd_valid),
        .pop   (pop),
        .wdata ({cmd.cmd_op, cmd.cmd_start_addr, cmd.cmd_end_addr, cmd.cmd_result_addr}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign cmd.cmd_ready = !full;

`ifdef PNM_SEQ_WATCHDOG_EN
    localparam int WD = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD-1:0] wd_cnt;

    // Cleared on the ISSUE->WAIT_EN transition so the first WAIT_EN cycle counts as 0.
    always_ff @(posedge clk) begin
        if (rst || state == S_ISSUE)                  wd_cnt <= '0;
        else if (state == S_WAIT_EN || state == S_RUN) wd_cnt <= wd_cnt + WD'(1);
    end

    assign wd_expired = (state == S_WAIT_EN || state == S_RUN) &&
                        (wd_cnt == WD'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: only a degenerate (negative) limit could ever fire, i.e. never.
    assign wd_expired = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        next     = state;
        pop      = 1'b0;
        err_set  = 1'b0;
        err_val  = ERR_NONE;
        done_set = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop  = 1'b1;
                    next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!op_legal(op_q)) begin
                    err_set = 1'b1;
                    err_val = ERR_OPCODE;
                    next    = S_IDLE;
                end else if (end_q < start_q) begin
                    err_set = 1'b1;
                    err_val = ERR_RANGE;
                    next    = S_IDLE;
                end else begin
                    next = S_ISSUE;
                end
            end
            S_ISSUE: next = S_WAIT_EN;
            S_WAIT_EN: begin
                if (wd_expired) begin
                    err_set = 1'b1;
                    err_val = ERR_TIMEOUT;
                    next    = S_IDLE;
                end else if (ctl_en) begin
                    next = S_RUN;
                end
            end
            S_RUN: begin
                if (ctl_done) begin
                    done_set = 1'b1;
                    next     = S_IDLE;
                end else if (wd_expired) begin
                    err_set = 1'b1;
                    err_val = ERR_TIMEOUT;
                    next    = S_IDLE;
                end
            end
            default: next = S_IDLE;
        endcase
    end

    // Outputs are registered off next-state so the strobe lines up exactly with ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            op_q            <= '0;
            start_q         <= '0;
            end_q           <= '0;
            res_q           <= '0;
            ctl_command     <= '0;
            ctl_start_addr  <= '0;
            ctl_end_addr    <= '0;
            ctl_result_addr <= '0;
            ctl_data_write  <= 1'b0;
            cmd.cmd_done    <= 1'b0;
            cmd.cmd_error   <= 1'b0;
            cmd.err_code    <= ERR_NONE;
        end else begin
            state          <= next;
            busy           <= (next != S_IDLE);
            cmd.cmd_done   <= done_set;
            cmd.cmd_error  <= err_set;
            if (err_set) cmd.err_code <= err_val;
            if (pop) {op_q, start_q, end_q, res_q} <= head;
            ctl_data_write  <= (next == S_ISSUE);
            ctl_command     <= (next == S_ISSUE) ? op_q    : '0;
            ctl_start_addr  <= (next == S_ISSUE) ? start_q : '0;
            ctl_end_addr    <= (next == S_ISSUE) ? end_q   : '0;
            ctl_result_addr <= (next == S_ISSUE) ? res_q   : '0;
        end
    end

endmodule
